// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter for an enable-gated register bank, with an optional
// per-requester lock that holds the write path for a back-to-back burst.
module regbank_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = 3,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [(1<<AW)-1:0]    wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic [2:0]            owner,
  output logic                  locked
);

  localparam int DEPTH = 1 << AW;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [2:0]       owner_q, owner_d;
  logic             locked_q, locked_d;
  logic [DEPTH-1:0] wr_en_q, wr_en_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];

  logic [NREQ-1:0]  gnt_c;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    own_idx;
  logic             accept;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*AW +: AW];
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign own_idx = owner_q[PW-1:0];

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin : p_grant
    logic [PW:0] sum;
    logic        found;
    gnt_c   = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    if (state_q == LOCKED) begin
      gnt_c[own_idx] = req[own_idx];
      win_idx        = own_idx;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, ptr_q} + (PW+1)'(k);
        if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
        if (!found && req[sum[PW-1:0]]) begin
          found              = 1'b1;
          win_idx            = sum[PW-1:0];
          gnt_c[sum[PW-1:0]] = 1'b1;
        end
      end
    end
    if (!rst_n) gnt_c = '0;
  end

  assign accept = |(req & gnt_c);

  always_comb begin : p_next
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_en_d[addr_arr[win_idx]] = 1'b1;
      wr_data_d                  = wdata_arr[win_idx];
      owner_d                    = 3'(win_idx);
      // A burst that keeps its lock leaves the rotation pointer alone.
      if (state_q == ARB || !lock[win_idx])
        ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
      state_d = lock[win_idx] ? LOCKED : ARB;
    end else if (state_q == LOCKED) begin
      state_d = ARB;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      locked_q  <= 1'b0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign gnt     = gnt_c;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign owner   = owner_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: behavioural arbiter/bank model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_regbank_write_arbiter;
  localparam int NREQ  = 4;
  localparam int AW    = 3;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ-1:0]       lock  = '0;
  logic [NREQ*AW-1:0]    addr  = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt;
  logic [DEPTH-1:0]      wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic [2:0]            owner;
  logic                  locked;

  regbank_write_arbiter #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .wr_en(wr_en), .wr_data(wr_data), .owner(owner), .locked(locked)
  );

  always #50 clk = ~clk;

  // Register bank driven by the DUT: one enable-gated word per wr_en bit.
  logic [WIDTH-1:0] bank [DEPTH];
  always @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++)
      if (wr_en[k]) bank[k] <= wr_data;
  end

  // Stimulus staging, copied onto the pins at the falling edge.
  logic [AW-1:0]    a_addr  [NREQ];
  logic [WIDTH-1:0] a_wdata [NREQ];

  // Model state.
  bit               m_locked  = 1'b0;
  int               m_ptr     = 0;
  int               m_owner   = 0;
  logic [DEPTH-1:0] m_wr_en   = '0;
  logic [WIDTH-1:0] m_wr_data = '0;
  logic [WIDTH-1:0] mbank [DEPTH];
  int               acc_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant rule: a lock holder sees only its own req; otherwise the requester
  // closest at or after ptr in circular order wins.
  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    int best, bestd, d;
    g = '0;
    best = -1;
    bestd = NREQ;
    if (!rst_n) return g;
    if (m_locked) begin
      g[m_owner] = req[m_owner];
      return g;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        d = (i - m_ptr + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    if (best >= 0) g[best] = 1'b1;
    return g;
  endfunction

  initial forever begin : model
    logic [NREQ-1:0] g;
    logic [AW-1:0]   wa;
    int              w;
    @(posedge clk);
    for (int k = 0; k < DEPTH; k++)
      if (m_wr_en[k]) mbank[k] = m_wr_data;
    g = model_gnt();
    w = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) w = i;
    if (!rst_n) begin
      m_locked  = 1'b0;
      m_ptr     = 0;
      m_owner   = 0;
      m_wr_en   = '0;
      m_wr_data = '0;
    end else if (w >= 0) begin
      wa         = addr[w*AW +: AW];
      m_wr_en    = '0;
      m_wr_en[wa] = 1'b1;
      m_wr_data  = wdata[w*WIDTH +: WIDTH];
      m_owner    = w;
      m_ptr      = (w + 1) % NREQ;
      m_locked   = lock[w];
      acc_q.push_back(w);
    end else begin
      m_wr_en  = '0;
      m_locked = 1'b0;
    end
  end

  initial forever begin : compare
    @(negedge clk);
    #10;
    check("gnt", 32'(gnt), 32'(model_gnt()));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("wr_en", 32'(wr_en), 32'(m_wr_en));
    check("wr_en_onehot", 32'($countones(wr_en) <= 1), 32'd1);
    check("wr_data", 32'(wr_data), 32'(m_wr_data));
    check("owner", 32'(owner), 32'(m_owner));
    check("locked", 32'(locked), 32'(m_locked));
    for (int k = 0; k < DEPTH; k++) check("bank", 32'(bank[k]), 32'(mbank[k]));
  end

  task automatic tick(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic rn);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW]       = a_addr[i];
      wdata[i*WIDTH +: WIDTH] = a_wdata[i];
    end
    req   = r;
    lock  = l;
    rst_n = rn;
    #20;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_addr[i]  = '0;
      a_wdata[i] = '0;
    end

    // Reset held for two edges with every requester asking.
    tick(4'b1111, 4'b0000, 1'b0);
    check("rst_gnt0", 32'(gnt), 32'h0);
    tick(4'b1111, 4'b0000, 1'b0);
    check("rst_gnt1", 32'(gnt), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_model_ptr", 32'(m_ptr), 32'h0);

    // Single write from requester 2 to word 5.
    a_addr[2] = 3'd5; a_wdata[2] = 8'hA5;
    tick(4'b0100, 4'b0000, 1'b1);
    check("single_gnt", 32'(gnt), 32'h4);
    tick(4'b0000, 4'b0000, 1'b1);
    check("single_wr_en", 32'(wr_en), 32'h20);
    check("single_wr_data", 32'(wr_data), 32'hA5);
    check("single_owner", 32'(owner), 32'h2);
    tick(4'b0000, 4'b0000, 1'b1);
    check("single_bank5", 32'(bank[5]), 32'hA5);
    check("idle_wr_en", 32'(wr_en), 32'h0);
    check("idle_wr_data_hold", 32'(wr_data), 32'hA5);
    check("single_model_ptr", 32'(m_ptr), 32'h3);

    // Round-robin from a fresh reset with all four requesting.
    tick(4'b0000, 4'b0000, 1'b0);
    acc_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      a_addr[i]  = AW'(2 * i);
      a_wdata[i] = WIDTH'(8'h30 + i);
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'b1111, 4'b0000, 1'b1);
      check("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
    end
    tick(4'b0000, 4'b0000, 1'b1);
    check("rr_last_wr_en", 32'(wr_en), 32'h40);
    check("rr_last_wr_data", 32'(wr_data), 32'h33);
    check("rr_count", 32'(acc_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < acc_q.size(); k++)
      check("rr_order", 32'(acc_q[k]), 32'(k % 4));

    // Wrap: accept 2 so the pointer sits at 3, then 3 and 0 compete.
    a_addr[2] = 3'd7; a_wdata[2] = 8'h77;
    tick(4'b0100, 4'b0000, 1'b1);
    check("wrap_gnt2", 32'(gnt), 32'h4);
    tick(4'b1001, 4'b0000, 1'b1);
    check("wrap_model_ptr", 32'(m_ptr), 32'h3);
    check("wrap_gnt3", 32'(gnt), 32'h8);
    tick(4'b1001, 4'b0000, 1'b1);
    check("wrap_gnt0", 32'(gnt), 32'h1);
    tick(4'b0000, 4'b0000, 1'b1);

    // Lock burst by requester 1 over words 0..3 with 0 and 3 also asking.
    a_addr[0] = 3'd7; a_wdata[0] = 8'h50;
    a_addr[3] = 3'd4; a_wdata[3] = 8'h53;
    for (int k = 0; k < 4; k++) begin
      a_addr[1]  = AW'(k);
      a_wdata[1] = WIDTH'(8'h40 + k);
      tick(4'b1011, (k == 3) ? 4'b0000 : 4'b0010, 1'b1);
      check("lock_gnt", 32'(gnt), 32'h2);
      check("lock_locked", 32'(locked), (k == 0) ? 32'h0 : 32'h1);
    end
    tick(4'b1011, 4'b0000, 1'b1);
    check("unlock_gnt3", 32'(gnt), 32'h8);
    check("unlock_locked", 32'(locked), 32'h0);
    check("unlock_wr_data", 32'(wr_data), 32'h43);
    tick(4'b1011, 4'b0000, 1'b1);
    check("unlock_gnt0", 32'(gnt), 32'h1);
    tick(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++)
      check("lock_bank", 32'(bank[k]), 32'(8'h40 + k));

    // Reset one cycle after a locked write to word 6.
    a_addr[2] = 3'd6; a_wdata[2] = 8'h66;
    tick(4'b0100, 4'b0100, 1'b1);
    check("mid_gnt_a", 32'(gnt), 32'h4);
    a_wdata[2] = 8'h6C;
    tick(4'b0100, 4'b0100, 1'b1);
    check("mid_gnt_b", 32'(gnt), 32'h4);
    check("mid_locked", 32'(locked), 32'h1);
    tick(4'b0100, 4'b0100, 1'b0);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    tick(4'b0000, 4'b0000, 1'b1);
    check("mid_bank6", 32'(bank[6]), 32'h6C);
    check("mid_locked_clr", 32'(locked), 32'h0);
    check("mid_wr_en", 32'(wr_en), 32'h0);
    check("mid_owner", 32'(owner), 32'h0);
    check("mid_model_ptr", 32'(m_ptr), 32'h0);
    tick(4'b1111, 4'b0000, 1'b1);
    check("mid_rearb_gnt", 32'(gnt), 32'h1);
    tick(4'b0000, 4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
